// File: rtl/rv_fetch_ctrl.sv
// Instruction fetch controller: one-outstanding-request bus master feeding decode,
// with a one-entry hold buffer for stalls and redirect handling for jumps/branches.
module rv_fetch_ctrl #(
   parameter logic [29:0] RESET_VECTOR = 30'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [29:0] i_target,
   output logic        o_bus_req,
   output logic [29:0] o_bus_addr,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_data,
   output logic [31:0] o_instr,
   output logic [29:0] o_pc,
   output logic [29:0] o_pc_p4,
   output logic        o_flush
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

   state_t      state_reg, state_next;
   // addr_reg is the address on the bus; tgt_reg parks a redirect target while an
   // abandoned request drains in DROP, so the bus address stays stable until ack.
   logic [29:0] addr_reg, addr_next;
   logic [29:0] tgt_reg, tgt_next;
   logic [31:0] instr_reg, instr_next;
   logic [29:0] pc_reg, pc_next;
   logic [29:0] pc_p4_reg, pc_p4_next;
   logic        valid_reg, valid_next;
   logic [31:0] hold_instr_reg, hold_instr_next;
   logic [29:0] hold_pc_reg, hold_pc_next;
   logic        hold_valid_reg, hold_valid_next;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_reg      <= IDLE;
         addr_reg       <= RESET_VECTOR;
         tgt_reg        <= RESET_VECTOR;
         instr_reg      <= 32'h0;
         pc_reg         <= 30'h0;
         pc_p4_reg      <= 30'h0;
         valid_reg      <= 1'b0;
         hold_instr_reg <= 32'h0;
         hold_pc_reg    <= 30'h0;
         hold_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         tgt_reg        <= tgt_next;
         instr_reg      <= instr_next;
         pc_reg         <= pc_next;
         pc_p4_reg      <= pc_p4_next;
         valid_reg      <= valid_next;
         hold_instr_reg <= hold_instr_next;
         hold_pc_reg    <= hold_pc_next;
         hold_valid_reg <= hold_valid_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      tgt_next        = tgt_reg;
      instr_next      = instr_reg;
      pc_next         = pc_reg;
      pc_p4_next      = pc_p4_reg;
      valid_next      = valid_reg;
      hold_instr_next = hold_instr_reg;
      hold_pc_next    = hold_pc_reg;
      hold_valid_next = hold_valid_reg;

      case (state_reg)
         IDLE: begin
            state_next = FETCH;
            if (i_redirect) begin
               addr_next  = i_target;
               valid_next = 1'b0;
            end else if (!i_stall) begin
               valid_next = 1'b0;
            end
         end

         FETCH: begin
            if (i_redirect) begin
               valid_next      = 1'b0;
               hold_valid_next = 1'b0;
               if (i_bus_ack) begin
                  addr_next = i_target;
               end else begin
                  tgt_next   = i_target;
                  state_next = DROP;
               end
            end else if (i_bus_ack) begin
               addr_next = addr_reg + 30'd1;
               if (i_stall) begin
                  hold_instr_next = i_bus_data;
                  hold_pc_next    = addr_reg;
                  hold_valid_next = 1'b1;
                  state_next      = HOLD;
               end else begin
                  instr_next = i_bus_data;
                  pc_next    = addr_reg;
                  pc_p4_next = addr_reg + 30'd1;
                  valid_next = 1'b1;
               end
            end else if (!i_stall) begin
               valid_next = 1'b0;
            end
         end

         HOLD: begin
            if (i_redirect) begin
               addr_next       = i_target;
               valid_next      = 1'b0;
               hold_valid_next = 1'b0;
               state_next      = FETCH;
            end else if (!i_stall) begin
               instr_next      = hold_instr_reg;
               pc_next         = hold_pc_reg;
               pc_p4_next      = hold_pc_reg + 30'd1;
               valid_next      = hold_valid_reg;
               hold_valid_next = 1'b0;
               state_next      = FETCH;
            end
         end

         DROP: begin
            if (i_redirect) begin
               valid_next = 1'b0;
               if (i_bus_ack) begin
                  addr_next  = i_target;
                  state_next = FETCH;
               end else begin
                  tgt_next = i_target;
               end
            end else begin
               if (i_bus_ack) begin
                  addr_next  = tgt_reg;
                  state_next = FETCH;
               end
               if (!i_stall) valid_next = 1'b0;
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign o_bus_req  = (state_reg == FETCH) || (state_reg == DROP);
   assign o_bus_addr = addr_reg;
   assign o_instr    = instr_reg;
   assign o_pc       = pc_reg;
   assign o_pc_p4    = pc_p4_reg;
   assign o_flush    = ~valid_reg;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// Directed bench for rv_fetch_ctrl: issued instructions are pushed to a scoreboard
// when the completing ack is driven and popped when decode should see them.
module tb_rv_fetch_ctrl;

   logic        i_clk = 1'b0;
   logic        i_reset_n = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_redirect = 1'b0;
   logic [29:0] i_target = 30'h0;
   logic        o_bus_req;
   logic [29:0] o_bus_addr;
   logic        i_bus_ack = 1'b0;
   logic [31:0] i_bus_data = 32'h0;
   logic [31:0] o_instr;
   logic [29:0] o_pc;
   logic [29:0] o_pc_p4;
   logic        o_flush;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [29:0] pc;
      logic [29:0] pc_p4;
   } exp_t;
   exp_t sb_q[$];

   rv_fetch_ctrl #(.RESET_VECTOR(30'h100)) dut (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_stall    (i_stall),
      .i_redirect (i_redirect),
      .i_target   (i_target),
      .o_bus_req  (o_bus_req),
      .o_bus_addr (o_bus_addr),
      .i_bus_ack  (i_bus_ack),
      .i_bus_data (i_bus_data),
      .o_instr    (o_instr),
      .o_pc       (o_pc),
      .o_pc_p4    (o_pc_p4),
      .o_flush    (o_flush)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, memory returns data = word address, sample #1 after edge.
   task automatic cyc(input logic rst_n, input logic stall, input logic redir,
                      input logic [29:0] tgt, input logic ack);
      @(negedge i_clk);
      i_reset_n  = rst_n;
      i_stall    = stall;
      i_redirect = redir;
      i_target   = tgt;
      i_bus_ack  = ack;
      i_bus_data = ack ? {2'b00, o_bus_addr} : 32'hDEAD_BEEF;
      @(posedge i_clk);
      #1;
      $display("cyc rst_n=%0b stall=%0b redir=%0b tgt=%h ack=%0b -> req=%0b addr=%h instr=%h pc=%h p4=%h flush=%0b",
               rst_n, stall, redir, tgt, ack, o_bus_req, o_bus_addr, o_instr, o_pc, o_pc_p4, o_flush);
   endtask

   task automatic push_exp(input logic [29:0] a);
      exp_t e;
      e.instr = {2'b00, a};
      e.pc    = a;
      e.pc_p4 = a + 30'd1;
      sb_q.push_back(e);
   endtask

   task automatic check_issue(input string tag);
      exp_t e;
      checks++;
      assert (sb_q.size() > 0) else begin
         errors++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_instr"}, o_instr, e.instr);
         chk({tag, "_pc"}, {2'b00, o_pc}, {2'b00, e.pc});
         chk({tag, "_pc_p4"}, {2'b00, o_pc_p4}, {2'b00, e.pc_p4});
         chk({tag, "_flush"}, {31'h0, o_flush}, 32'h0);
      end
   endtask

   initial begin
      // Reset state
      cyc(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 30'h0, 1'b1);
      chk("rst_req",   {31'h0, o_bus_req}, 32'h0);
      chk("rst_addr",  {2'b00, o_bus_addr}, 32'h100);
      chk("rst_instr", o_instr, 32'h0);
      chk("rst_pc",    {2'b00, o_pc}, 32'h0);
      chk("rst_p4",    {2'b00, o_pc_p4}, 32'h0);
      chk("rst_flush", {31'h0, o_flush}, 32'h1);

      // Release; ack during IDLE is ignored
      cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      chk("idle_req",   {31'h0, o_bus_req}, 32'h1);
      chk("idle_addr",  {2'b00, o_bus_addr}, 32'h100);
      chk("idle_flush", {31'h0, o_flush}, 32'h1);

      // Back-to-back fetch
      push_exp(30'h100); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("seq100");
      chk("seq_addr101", {2'b00, o_bus_addr}, 32'h101);
      push_exp(30'h101); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("seq101");

      // Ack under stall -> HOLD, outputs frozen
      cyc(1'b1, 1'b1, 1'b0, 30'h0, 1'b1);
      chk("hold_req",   {31'h0, o_bus_req}, 32'h0);
      chk("hold_instr", o_instr, 32'h101);
      cyc(1'b1, 1'b1, 1'b0, 30'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 30'h0, 1'b0);
      chk("hold3_instr", o_instr, 32'h101);
      chk("hold3_flush", {31'h0, o_flush}, 32'h0);
      chk("hold3_req",   {31'h0, o_bus_req}, 32'h0);
      push_exp(30'h102); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b0);
      check_issue("unhold102");
      chk("resume_addr", {2'b00, o_bus_addr}, 32'h103);
      chk("resume_req",  {31'h0, o_bus_req}, 32'h1);
      push_exp(30'h103); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("seq103");

      // Redirect without ack -> DROP; late ack discarded
      cyc(1'b1, 1'b0, 1'b1, 30'h200, 1'b0);
      chk("drop_flush", {31'h0, o_flush}, 32'h1);
      chk("drop_addr",  {2'b00, o_bus_addr}, 32'h104);
      chk("drop_req",   {31'h0, o_bus_req}, 32'h1);
      cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      chk("late_flush", {31'h0, o_flush}, 32'h1);
      chk("late_addr",  {2'b00, o_bus_addr}, 32'h200);
      push_exp(30'h200); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("redir200");

      // Repeated redirect while draining in DROP
      cyc(1'b1, 1'b0, 1'b1, 30'h280, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 30'h290, 1'b0);
      chk("drop2_addr", {2'b00, o_bus_addr}, 32'h201);
      cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      chk("drop2_tgt", {2'b00, o_bus_addr}, 32'h290);
      push_exp(30'h290); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("redir290");

      // Redirect coincident with ack and stall
      cyc(1'b1, 1'b1, 1'b1, 30'h300, 1'b1);
      chk("coin_flush", {31'h0, o_flush}, 32'h1);
      chk("coin_addr",  {2'b00, o_bus_addr}, 32'h300);
      push_exp(30'h300); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("redir300");

      // PC wrap
      cyc(1'b1, 1'b0, 1'b1, 30'h3FFF_FFFF, 1'b1);
      chk("wrap_pre_addr", {2'b00, o_bus_addr}, 32'h3FFF_FFFF);
      push_exp(30'h3FFF_FFFF); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("wrap_top");
      chk("wrap_addr", {2'b00, o_bus_addr}, 32'h0);
      push_exp(30'h0); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("wrap_zero");

      // Bubble when not stalled and nothing issued; hold when stalled
      cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b0);
      chk("bubble_flush", {31'h0, o_flush}, 32'h1);
      push_exp(30'h1); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("seq001");
      cyc(1'b1, 1'b1, 1'b0, 30'h0, 1'b0);
      chk("stall_instr", o_instr, 32'h1);
      chk("stall_flush", {31'h0, o_flush}, 32'h0);

      // Reset mid-transaction; ack right after release ignored
      cyc(1'b0, 1'b0, 1'b0, 30'h0, 1'b0);
      chk("mrst_req",   {31'h0, o_bus_req}, 32'h0);
      chk("mrst_addr",  {2'b00, o_bus_addr}, 32'h100);
      chk("mrst_flush", {31'h0, o_flush}, 32'h1);
      cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      chk("mrel_flush", {31'h0, o_flush}, 32'h1);
      chk("mrel_addr",  {2'b00, o_bus_addr}, 32'h100);
      push_exp(30'h100); cyc(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      check_issue("restart100");

      checks++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: observed %0d entries expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
